aes128_mm_queue: RTL and testbench

Parametrised Avalon-MM slave front end for the AES128_top encryption core, with an input job FIFO and an output result FIFO, each DEPTH entries of 128 bits.
- Software stages a plaintext block and pushes it; an internal FSM launches jobs back-to-back without CPU polling between blocks.
- Results queue for later readout.
- Replaces the single-shot register wrapper in the SoC crypto subsystem.

---
 rtl/aes_mm_pkg.sv | 42 ++++
 rtl/AES128_top.sv | 126 ++++++++++++
 rtl/aes_mm_fifo.sv | 54 +++++
 rtl/aes128_mm_queue.sv | 145 ++++++++++++++
 tb/tb_aes128_mm_queue.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_mm_pkg.sv
// Shared definitions for the AES-128 Avalon-MM queue: register map, CTRL/STATUS
// bit positions and the job FSM state type.
package aes_mm_pkg;

    localparam logic [3:0] ADDR_DIN0   = 4'd0;
    localparam logic [3:0] ADDR_DIN1   = 4'd1;
    localparam logic [3:0] ADDR_DIN2   = 4'd2;
    localparam logic [3:0] ADDR_DIN3   = 4'd3;
    localparam logic [3:0] ADDR_KEY0   = 4'd4;
    localparam logic [3:0] ADDR_KEY1   = 4'd5;
    localparam logic [3:0] ADDR_KEY2   = 4'd6;
    localparam logic [3:0] ADDR_KEY3   = 4'd7;
    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_STATUS = 4'd9;
    localparam logic [3:0] ADDR_POP    = 4'd10;

    localparam int CTRL_PUSH   = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_CLR    = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int POP_HEAD    = 0;

    localparam int ST_BUSY      = 0;
    localparam int ST_IN_FULL   = 1;
    localparam int ST_IN_EMPTY  = 2;
    localparam int ST_OUT_FULL  = 3;
    localparam int ST_OUT_EMPTY = 4;
    localparam int ST_OVF       = 5;
    localparam int ST_UNF       = 6;
    localparam int ST_IRQ_EN    = 7;
    localparam int ST_IN_CNT    = 8;
    localparam int ST_OUT_CNT   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        STORE
    } mm_state_t;

endpackage

// File: rtl/AES128_top.sv
// Iterative AES-128 encryption core: one round per clock, done pulses for one
// cycle when dataout holds the ciphertext (byte 0 of the block in bits [127:120]).
module AES128_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] din,
    input  logic [127:0] key,
    output logic [127:0] dataout,
    output logic         done
);

    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [7:0]   r_rcon;
    logic [3:0]   r_rnd;
    logic         r_busy;
    logic [127:0] w_next_rk;
    logic [127:0] w_next_state;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the field inverse (a^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, rot, tmp;
        w0  = rk[127:96];
        w1  = rk[95:64];
        w2  = rk[63:32];
        w3  = rk[31:0];
        rot = {w3[23:0], w3[31:24]};
        tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon, 24'h0};
        w0  = w0 ^ tmp;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = s[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];
                a1 = t[4*c+1];
                a2 = t[4*c+2];
                a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i] ^ rk[127-8*i -: 8];
        return res;
    endfunction

    assign w_next_rk    = key_next(r_rk, r_rcon);
    assign w_next_state = aes_round(r_state, w_next_rk, r_rnd == 4'd10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            r_rk    <= '0;
            r_rcon  <= '0;
            r_rnd   <= '0;
            r_busy  <= 1'b0;
            done    <= 1'b0;
            dataout <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r_state <= din ^ key;
                r_rk    <= key;
                r_rcon  <= 8'h01;
                r_rnd   <= 4'd1;
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_state <= w_next_state;
                r_rk    <= w_next_rk;
                r_rcon  <= xt(r_rcon);
                r_rnd   <= r_rnd + 4'd1;
                if (r_rnd == 4'd10) begin
                    r_busy  <= 1'b0;
                    done    <= 1'b1;
                    dataout <= w_next_state;
                end
            end
        end
    end

endmodule

// File: rtl/aes_mm_fifo.sv
// 128-bit synchronous FIFO with single-cycle flush; a push in the flush cycle
// lands in the freshly emptied FIFO. Head reads 0 while empty.
module aes_mm_fifo #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [127:0]     i_din,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic [127:0]     o_head
);

    logic [127:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_push_ok = i_push && (i_flush || !o_full);
    assign w_pop_ok  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[i_flush ? '0 : r_wr_ptr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_push_ok ? PTR_W'(1) : '0;
            r_count  <= w_push_ok ? CNT_W'(1) : '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        end
    end

endmodule

// File: rtl/aes128_mm_queue.sv
// Avalon-MM queued front end for AES128_top: job FIFO in, result FIFO out, FSM
// launches jobs back-to-back. Optional interrupt output under AES_MM_IRQ_EN.
module aes128_mm_queue
    import aes_mm_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iChipSelect_n,
    input  logic        iWrite_n,
    input  logic        iRead_n,
    input  logic [3:0]  iAddress,
    input  logic [31:0] iData,
    output logic [31:0] oData
`ifdef AES_MM_IRQ_EN
    ,
    output logic        oIrq
`endif
);

    mm_state_t        r_state, w_next_state;
    logic [127:0]     r_din_stage, r_key, r_core_din, r_core_key;
    logic             r_core_start, r_ovf, r_unf;
    logic             w_wr, w_rd, w_ctrl_wr, w_push_req, w_flush, w_clr, w_pop_req;
    logic             w_ovf_evt, w_unf_evt, w_in_push, w_busy, w_irq_en;
    logic             w_in_full, w_in_empty, w_out_full, w_out_empty, w_core_done;
    logic [CNT_W-1:0] w_in_count, w_out_count;
    logic [127:0]     w_in_head, w_out_head, w_core_dout;
    logic [31:0]      w_status, w_rd_data;

    assign w_wr       = !iChipSelect_n && !iWrite_n;
    assign w_rd       = !iChipSelect_n && !iRead_n;
    assign w_ctrl_wr  = w_wr && (iAddress == ADDR_CTRL);
    assign w_push_req = w_ctrl_wr && iData[CTRL_PUSH];
    assign w_flush    = w_ctrl_wr && iData[CTRL_FLUSH];
    assign w_clr      = w_ctrl_wr && iData[CTRL_CLR];
    assign w_pop_req  = w_wr && (iAddress == ADDR_POP) && iData[POP_HEAD];
    // A flush in the same word makes room before the push is considered.
    assign w_ovf_evt  = w_push_req && w_in_full && !w_flush;
    assign w_in_push  = w_push_req && !w_ovf_evt;
    assign w_unf_evt  = w_pop_req && w_out_empty;
    assign w_busy     = (r_state != IDLE);

    aes_mm_fifo #(.DEPTH(DEPTH)) u_in_fifo (
        .i_clk(iClk), .i_rst_n(iReset_n), .i_push(w_in_push), .i_pop(r_state == LOAD),
        .i_flush(w_flush), .i_din(r_din_stage), .o_full(w_in_full), .o_empty(w_in_empty),
        .o_count(w_in_count), .o_head(w_in_head)
    );

    aes_mm_fifo #(.DEPTH(DEPTH)) u_out_fifo (
        .i_clk(iClk), .i_rst_n(iReset_n), .i_push(r_state == STORE), .i_pop(w_pop_req),
        .i_flush(w_flush), .i_din(w_core_dout), .o_full(w_out_full), .o_empty(w_out_empty),
        .o_count(w_out_count), .o_head(w_out_head)
    );

    AES128_top u_core (
        .clk(iClk), .rst(~iReset_n), .start(r_core_start), .din(r_core_din),
        .key(r_core_key), .dataout(w_core_dout), .done(w_core_done)
    );

    // Launch only when the result will have a free out-FIFO slot.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_in_count != '0 && w_out_count < CNT_W'(DEPTH)) w_next_state = LOAD;
            LOAD:    w_next_state = START;
            START:   w_next_state = WAIT;
            WAIT:    if (w_core_done) w_next_state = STORE;
            STORE:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state      <= IDLE;
            r_din_stage  <= '0;
            r_key        <= '0;
            r_core_din   <= '0;
            r_core_key   <= '0;
            r_core_start <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            oData        <= '0;
        end else begin
            r_state      <= w_next_state;
            r_core_start <= (r_state == LOAD);
            if (w_wr && iAddress[3:2] == ADDR_DIN0[3:2]) r_din_stage[{iAddress[1:0], 5'd0} +: 32] <= iData;
            if (w_wr && iAddress[3:2] == ADDR_KEY0[3:2]) r_key[{iAddress[1:0], 5'd0} +: 32] <= iData;
            if (r_state == LOAD) begin
                r_core_din <= w_in_head;
                r_core_key <= r_key;
            end
            r_ovf <= w_ovf_evt | (r_ovf & ~w_clr);
            r_unf <= w_unf_evt | (r_unf & ~w_clr);
            if (w_rd) oData <= w_rd_data;
        end
    end

`ifdef AES_MM_IRQ_EN
    logic r_irq_en;
    assign w_irq_en = r_irq_en;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_irq_en <= 1'b0;
            oIrq     <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= iData[CTRL_IRQ_EN];
            oIrq <= r_irq_en & (!w_out_empty | r_ovf | r_unf);
        end
    end
`else
    assign w_irq_en = 1'b0;
`endif

    always_comb begin
        w_status                  = '0;
        w_status[ST_BUSY]         = w_busy;
        w_status[ST_IN_FULL]      = w_in_full;
        w_status[ST_IN_EMPTY]     = w_in_empty;
        w_status[ST_OUT_FULL]     = w_out_full;
        w_status[ST_OUT_EMPTY]    = w_out_empty;
        w_status[ST_OVF]          = r_ovf;
        w_status[ST_UNF]          = r_unf;
        w_status[ST_IRQ_EN]       = w_irq_en;
        w_status[ST_IN_CNT +: 8]  = 8'(w_in_count);
        w_status[ST_OUT_CNT +: 8] = 8'(w_out_count);
    end

    always_comb begin
        w_rd_data = '0;
        case (iAddress)
            ADDR_DIN0:   w_rd_data = w_out_head[31:0];
            ADDR_DIN1:   w_rd_data = w_out_head[63:32];
            ADDR_DIN2:   w_rd_data = w_out_head[95:64];
            ADDR_DIN3:   w_rd_data = w_out_head[127:96];
            ADDR_STATUS: w_rd_data = w_status;
            default:     w_rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_aes128_mm_queue.sv
// Directed bench for aes128_mm_queue: known-answer AES vectors through the
// queue, overflow/underflow flags, backpressure, flush and mid-job reset.
module tb_aes128_mm_queue;
    import aes_mm_pkg::*;

    logic        iClk = 1'b0;
    logic        iReset_n = 1'b0;
    logic        iChipSelect_n = 1'b1;
    logic        iWrite_n = 1'b1;
    logic        iRead_n = 1'b1;
    logic [3:0]  iAddress = '0;
    logic [31:0] iData = '0;
    logic [31:0] oData;
`ifdef AES_MM_IRQ_EN
    logic        oIrq;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] K_FIPS  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_FIPS  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_FIPS  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_NIST  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_ZERO  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic [127:0] pt [4];
    logic [127:0] ct [4];

    always #5 iClk = ~iClk;

    aes128_mm_queue #(.DEPTH(4)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iChipSelect_n(iChipSelect_n), .iWrite_n(iWrite_n),
        .iRead_n(iRead_n), .iAddress(iAddress), .iData(iData), .oData(oData)
`ifdef AES_MM_IRQ_EN
        , .oIrq(oIrq)
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge iClk);
        iChipSelect_n = 1'b0; iWrite_n = 1'b0; iAddress = a; iData = d;
        @(negedge iClk);
        iChipSelect_n = 1'b1; iWrite_n = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge iClk);
        iChipSelect_n = 1'b0; iRead_n = 1'b0; iAddress = a;
        @(negedge iClk);
        iChipSelect_n = 1'b1; iRead_n = 1'b1;
        d = oData;
    endtask

    task automatic write_key(input logic [127:0] k);
        for (int i = 0; i < 4; i++) bus_write(ADDR_KEY0 + 4'(i), k[32*i +: 32]);
    endtask

    task automatic push_block(input logic [127:0] b);
        for (int i = 0; i < 4; i++) bus_write(ADDR_DIN0 + 4'(i), b[32*i +: 32]);
        bus_write(ADDR_CTRL, 32'h1);
    endtask

    task automatic wait_out_atleast(input int n, input string tag);
        logic [31:0] st;
        int polls;
        polls = 0;
        bus_read(ADDR_STATUS, st);
        while (int'(st[23:16]) < n && polls < 100) begin
            bus_read(ADDR_STATUS, st);
            polls++;
        end
        check_eq(tag, 128'(int'(st[23:16]) >= n), 128'd1);
    endtask

    task automatic drain_one(input string tag);
        logic [31:0]  d;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) begin
            bus_read(ADDR_DIN0 + 4'(i), d);
            res[32*i +: 32] = d;
        end
        check_eq({tag, "_sb_nonempty"}, 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) check_eq(tag, res, exp_q.pop_front());
        bus_write(ADDR_POP, 32'h1);
    endtask

    task automatic drain_all(input string tag);
        while (exp_q.size() > 0) begin
            wait_out_atleast(1, {tag, "_wait"});
            drain_one(tag);
        end
    endtask

    initial begin
        logic [31:0] st;
        logic [31:0] d;
        pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a; ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710; ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;

        repeat (3) @(negedge iClk);
        iReset_n = 1'b1;
        @(negedge iClk);
        check_eq("rst_odata", 128'(oData), 128'd0);
        bus_read(ADDR_STATUS, st);
        check_eq("rst_status", 128'(st), 128'h14);

        // FIPS-197 known answer
        write_key(K_FIPS);
        push_block(P_FIPS);
        wait_out_atleast(1, "fips_wait");
        bus_read(ADDR_DIN0, d);
        check_eq("fips_w0", 128'(d), 128'h70b4c55a);
        bus_read(ADDR_DIN3, d);
        check_eq("fips_w3", 128'(d), 128'h69c4e0d8);
        bus_write(ADDR_POP, 32'h1);
        bus_read(ADDR_STATUS, st);
        check_eq("fips_out_empty", 128'(st[4]), 128'd1);
        check_eq("fips_status", 128'(st), 128'h14);

        // Burst of five blocks; launches keep the in-FIFO from filling
        write_key(K_NIST);
        for (int i = 0; i < 4; i++) begin
            push_block(pt[i]);
            exp_q.push_back(ct[i]);
        end
        push_block(P_B);
        exp_q.push_back(C_B);
        bus_read(ADDR_STATUS, st);
        check_eq("burst_no_ovf", 128'(st[5]), 128'd0);
        drain_all("burst");

        // Backpressure: out-FIFO full, two pending jobs
        for (int i = 0; i < 4; i++) begin
            push_block(pt[i]);
            exp_q.push_back(ct[i]);
        end
        wait_out_atleast(4, "bp_fill");
        push_block(pt[0]); exp_q.push_back(ct[0]);
        push_block(pt[1]); exp_q.push_back(ct[1]);
        repeat (20) @(negedge iClk);
        bus_read(ADDR_STATUS, st);
        check_eq("bp_busy", 128'(st[0]), 128'd0);
        check_eq("bp_in_cnt", 128'(st[15:8]), 128'd2);
        check_eq("bp_out_cnt", 128'(st[23:16]), 128'd4);
        drain_one("bp_pop1");
        wait_out_atleast(4, "bp_refill");
        repeat (20) @(negedge iClk);
        bus_read(ADDR_STATUS, st);
        check_eq("bp_one_launch", 128'(st[15:8]), 128'd1);
        check_eq("bp_idle", 128'(st[0]), 128'd0);

        // Overflow: fill the in-FIFO behind the stalled out-FIFO, then one more
        push_block(pt[2]); exp_q.push_back(ct[2]);
        push_block(pt[3]); exp_q.push_back(ct[3]);
        push_block(pt[0]); exp_q.push_back(ct[0]);
        push_block(pt[1]);
        bus_read(ADDR_STATUS, st);
        check_eq("ovf_set", 128'(st[5]), 128'd1);
        check_eq("ovf_in_cnt", 128'(st[15:8]), 128'd4);
        check_eq("ovf_in_full", 128'(st[1]), 128'd1);
        bus_write(ADDR_CTRL, 32'h4);
        bus_read(ADDR_STATUS, st);
        check_eq("ovf_clr", 128'(st[5]), 128'd0);
        drain_all("bp_drain");

        // Underflow and clear
        bus_write(ADDR_POP, 32'h1);
        bus_read(ADDR_STATUS, st);
        check_eq("unf_set", 128'(st[6]), 128'd1);
        bus_write(ADDR_CTRL, 32'h4);
        bus_read(ADDR_STATUS, st);
        check_eq("unf_clr", 128'(st), 128'h14);

        // Key change and flush while a job is in WAIT
        write_key(K_NIST);
        for (int i = 0; i < 4; i++) bus_write(ADDR_DIN0 + 4'(i), P_B[32*i +: 32]);
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_CTRL, 32'h1);
        write_key(K_FIPS);
        bus_write(ADDR_CTRL, 32'h2);
        exp_q.push_back(C_B);
        wait_out_atleast(1, "flush_wait");
        repeat (4) @(negedge iClk);
        bus_read(ADDR_STATUS, st);
        check_eq("flush_in_cnt", 128'(st[15:8]), 128'd0);
        check_eq("flush_out_cnt", 128'(st[23:16]), 128'd1);
        drain_one("flush_old_key");
        push_block(P_FIPS);
        exp_q.push_back(C_FIPS);
        wait_out_atleast(1, "new_key_wait");
        drain_one("new_key");

        // Asynchronous reset in the middle of a job
        push_block(pt[2]);
        bus_read(ADDR_STATUS, st);
        check_eq("pre_rst_busy", 128'(st[0]), 128'd1);
        repeat (4) @(negedge iClk);
        #2 iReset_n = 1'b0;
        repeat (2) @(negedge iClk);
        check_eq("rst_mid_odata", 128'(oData), 128'd0);
        iReset_n = 1'b1;
        @(negedge iClk);
        bus_read(ADDR_STATUS, st);
        check_eq("rst_mid_status", 128'(st), 128'h14);
        bus_read(ADDR_DIN0, d);
        check_eq("rst_mid_head", 128'(d), 128'd0);
        bus_write(ADDR_CTRL, 32'h1);
        exp_q.push_back(C_ZERO);
        wait_out_atleast(1, "post_rst_wait");
        drain_one("post_rst_zero");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
